// File: rtl/sqrt_nr_pipe.sv
// Fixed-point square root using the non-restoring digit-by-digit method.
// Resolves ITER_PER_CYCLE root bits per clock behind valid/ready handshakes.
module sqrt_nr_pipe #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned FRAC_BITS      = 16,
  parameter int unsigned ITER_PER_CYCLE = 1,
  parameter int unsigned ROUND_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 x,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 root,
  output logic [(WIDTH+FRAC_BITS)/2:0]     rem,
  output logic                             exact,
  output logic                             busy
);

  localparam int unsigned ROOT_W = (WIDTH + FRAC_BITS) / 2;
  localparam int unsigned RAD_W  = 2 * ROOT_W;
  localparam int unsigned REM_W  = ROOT_W + 2;
  localparam int unsigned N_ITER = ROOT_W / ITER_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

  if (FRAC_BITS > WIDTH) begin : g_bad_frac
    $error("sqrt_nr_pipe: FRAC_BITS must not exceed WIDTH");
  end
  if (((WIDTH + FRAC_BITS) % 2) != 0) begin : g_bad_parity
    $error("sqrt_nr_pipe: WIDTH+FRAC_BITS must be even");
  end
  if ((ITER_PER_CYCLE == 0) || ((ROOT_W % ITER_PER_CYCLE) != 0)) begin : g_bad_iter
    $error("sqrt_nr_pipe: ITER_PER_CYCLE must divide the root width");
  end
  if (ROUND_MODE > 1) begin : g_bad_round
    $error("sqrt_nr_pipe: ROUND_MODE must be 0 or 1");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [RAD_W-1:0]    rad_q;
  logic [ROOT_W-1:0]   q_q;
  logic [REM_W-1:0]    r_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [RAD_W-1:0]    rad_step;
  logic [ROOT_W-1:0]   q_step;
  logic [REM_W-1:0]    r_step;
  logic [REM_W-1:0]    r_shift;
  logic [REM_W-1:0]    r_fin;
  logic [ROOT_W-1:0]   root_rnd;

  // Remainder is two's complement; modular arithmetic is exact because every
  // intermediate result of a step fits in REM_W signed bits.
  always_comb begin
    rad_step = rad_q;
    q_step   = q_q;
    r_step   = r_q;
    r_shift  = '0;
    for (int i = 0; i < int'(ITER_PER_CYCLE); i++) begin
      r_shift = {r_step[REM_W-3:0], rad_step[RAD_W-1 -: 2]};
      if (!r_step[REM_W-1]) begin
        r_step = r_shift - {q_step, 2'b01};
      end else begin
        r_step = r_shift + {q_step, 2'b11};
      end
      q_step   = (q_step << 1) | ROOT_W'(!r_step[REM_W-1]);
      rad_step = rad_step << 2;
    end
  end

  always_comb begin
    r_fin = r_q;
    if (r_q[REM_W-1]) begin
      r_fin = r_q + {1'b0, q_q, 1'b1};
    end
    root_rnd = q_q;
    // Round up when the true root exceeds q+0.5, i.e. rem > q; never wrap.
    if ((ROUND_MODE == 1) && (r_fin[ROOT_W:0] > {1'b0, q_q}) && !(&q_q)) begin
      root_rnd = q_q + ROOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rad_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      root      <= '0;
      rem       <= '0;
      exact     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            rad_q    <= RAD_W'(x) << FRAC_BITS;
            q_q      <= '0;
            r_q      <= '0;
            cnt_q    <= CNT_W'(N_ITER);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            rad_q <= rad_step;
            q_q   <= q_step;
            r_q   <= r_step;
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            root      <= WIDTH'(root_rnd);
            rem       <= r_fin[ROOT_W:0];
            exact     <= (r_fin == '0);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_nr_pipe.sv
// Bench for sqrt_nr_pipe: a default (truncating, 1 bit/clk) instance and a
// rounding 4 bits/clk instance share the stimulus; results compared to isqrt.
module tb_sqrt_nr_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned RW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  x;

  logic          in_ready_a, out_valid_a, exact_a, busy_a;
  logic [W-1:0]  root_a;
  logic [RW:0]   rem_a;
  logic          in_ready_b, out_valid_b, exact_b, busy_b;
  logic [W-1:0]  root_b;
  logic [RW:0]   rem_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_nr_pipe #(.WIDTH(32), .FRAC_BITS(16), .ITER_PER_CYCLE(1), .ROUND_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .x(x),
    .out_valid(out_valid_a), .out_ready(out_ready), .root(root_a), .rem(rem_a),
    .exact(exact_a), .busy(busy_a)
  );

  sqrt_nr_pipe #(.WIDTH(32), .FRAC_BITS(16), .ITER_PER_CYCLE(4), .ROUND_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .x(x),
    .out_valid(out_valid_b), .out_ready(out_ready), .root(root_b), .rem(rem_b),
    .exact(exact_b), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] xv;
    logic [31:0] rt_trunc;
    logic [31:0] rt_round;
    logic [31:0] rm;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Largest r with r*r <= x*2^16, found by binary search.
  task automatic ref_sqrt(input logic [31:0] xv, output longint unsigned rt,
                          output longint unsigned rr, output longint unsigned rm);
    longint unsigned rad, lo, hi, mid;
    rad = {32'b0, xv} << 16;
    lo  = 0;
    hi  = (64'd1 << RW) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= rad) lo = mid;
      else hi = mid - 1;
    end
    rt = lo;
    rm = rad - lo * lo;
    rr = ((rm > rt) && (rt != (64'd1 << RW) - 1)) ? rt + 1 : rt;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && !(in_ready_a && in_ready_b); c++) begin
      @(posedge clk); #1;
    end
    chk("idle wait", {62'b0, in_ready_a, in_ready_b}, 64'd3);
  endtask

  task automatic do_op(input logic [31:0] xv, input longint unsigned e_t,
                       input longint unsigned e_r, input longint unsigned e_m,
                       input string tag);
    int          lat_a, lat_b;
    logic [31:0] ra, rb;
    logic [RW:0] ma, mb;
    logic        xa, xb;
    bit          ga, gb;
    wait_idle();
    x = xv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ga = 0; gb = 0; lat_a = -1; lat_b = -1;
    ra = '0; rb = '0; ma = '0; mb = '0; xa = 0; xb = 0;
    for (int c = 1; c <= 60 && !(ga && gb); c++) begin
      @(posedge clk); #1;
      if (out_valid_a && !ga) begin
        ga = 1; lat_a = c; ra = root_a; ma = rem_a; xa = exact_a;
      end
      if (out_valid_b && !gb) begin
        gb = 1; lat_b = c; rb = root_b; mb = rem_b; xb = exact_b;
      end
    end
    chk({tag, " lat_a"}, 64'(lat_a), 64'd25);
    chk({tag, " lat_b"}, 64'(lat_b), 64'd7);
    chk({tag, " root_a"}, {32'b0, ra}, e_t);
    chk({tag, " root_b"}, {32'b0, rb}, e_r);
    chk({tag, " rem_a"}, {39'b0, ma}, e_m);
    chk({tag, " rem_b"}, {39'b0, mb}, e_m);
    chk({tag, " exact_a"}, {63'b0, xa}, {63'b0, e_m == 0});
    chk({tag, " exact_b"}, {63'b0, xb}, {63'b0, e_m == 0});
  endtask

  initial begin
    vec_t vecs[8];
    longint unsigned rt, rr, rm;
    logic [31:0] xv;

    vecs[0] = '{32'h0010_0000, 32'h0004_0000, 32'h0004_0000, 32'd0};
    vecs[1] = '{32'h0002_0000, 32'h0001_6A09, 32'h0001_6A0A, 32'd166831};
    vecs[2] = '{32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'd33488895};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'd0};
    vecs[4] = '{32'h0009_0000, 32'h0003_0000, 32'h0003_0000, 32'd0};
    vecs[5] = '{32'h0000_0001, 32'h0000_0100, 32'h0000_0100, 32'd0};
    vecs[6] = '{32'h0000_0003, 32'h0000_01BB, 32'h0000_01BB, 32'd359};
    vecs[7] = '{32'h0003_0000, 32'h0001_BB67, 32'h0001_BB68, 32'd154767};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst in_ready", {62'b0, in_ready_a, in_ready_b}, 64'd3);
    chk("rst out_valid", {62'b0, out_valid_a, out_valid_b}, 64'd0);
    chk("rst busy", {62'b0, busy_a, busy_b}, 64'd0);
    chk("rst exact", {62'b0, exact_a, exact_b}, 64'd0);
    chk("rst root", {root_a, root_b}, 64'd0);
    chk("rst rem", {14'b0, rem_a, rem_b}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].xv, {32'b0, vecs[i].rt_trunc}, {32'b0, vecs[i].rt_round},
            {32'b0, vecs[i].rm}, $sformatf("vec%0d", i));
    end

    // Backpressure: results held, new operands ignored, then one transfer.
    wait_idle();
    out_ready = 1'b0;
    x = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 60 && !out_valid_a; c++) begin
      @(posedge clk); #1;
    end
    chk("bp out_valid", {62'b0, out_valid_a, out_valid_b}, 64'd3);
    for (int k = 0; k < 10; k++) begin
      x = $urandom;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp hold root_a", {32'b0, root_a}, 64'h0001_6A09);
      chk("bp hold root_b", {32'b0, root_b}, 64'h0001_6A0A);
      chk("bp hold rem", {14'b0, rem_a, rem_b}, {14'b0, 25'd166831, 25'd166831});
      chk("bp hold flags", {60'b0, out_valid_a, out_valid_b, in_ready_a, in_ready_b},
          64'b1100);
      chk("bp hold exact", {62'b0, exact_a, exact_b}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release flags", {60'b0, out_valid_a, out_valid_b, in_ready_a, in_ready_b},
        64'b0011);
    chk("bp release busy", {62'b0, busy_a, busy_b}, 64'd0);
    chk("bp release root", {32'b0, root_a}, 64'h0001_6A09);

    // Reset five clocks into BUSY discards the operation.
    wait_idle();
    x = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid busy", {62'b0, busy_a, busy_b}, 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst flags", {60'b0, out_valid_a, out_valid_b, in_ready_a, in_ready_b},
        64'b0011);
    chk("mid rst busy", {62'b0, busy_a, busy_b}, 64'd0);
    chk("mid rst root", {root_a, root_b}, 64'd0);
    do_op(32'h0009_0000, 64'h0003_0000, 64'h0003_0000, 64'd0, "after rst");

    for (int i = 0; i < 100; i++) begin
      xv = (i % 4 == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
      ref_sqrt(xv, rt, rr, rm);
      do_op(xv, rt, rr, rm, $sformatf("rand%0d x=%0h", i, xv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
